// File: rtl/apple_bus_frontend.sv
// Apple II slot bus front-end: strobe synchronisers, $C800 ownership, read OE timing and device write qualification.
// Optional ROM banking register is enabled by defining ROM_BANK_EN.
module apple_bus_frontend #(
    parameter int         SYNC_STAGES   = 2,
    parameter int         OE_DELAY      = 2,
    parameter int         BANK_W        = 2,
    parameter logic [3:0] BANK_REG_ADDR = 4'hE
) (
    input  logic                 fclk,
    input  logic                 _reset,
    input  logic [11:0]          addr,
    input  logic                 rw,
    input  logic                 q3,
    input  logic                 _iosel,
    input  logic                 _iostrobe,
    input  logic                 _devsel,
    input  logic [7:0]           data_in,
    input  logic [7:0]           rom_data,
    input  logic [7:0]           dev_data,
    output logic [7:0]           data_out,
    output logic                 data_oe,
    output logic                 _en245,
    output logic [12+BANK_W-1:0] rom_addr,
    output logic                 exp_active,
    output logic                 dev_wr_strobe,
    output logic [3:0]           dev_wr_addr,
    output logic [7:0]           dev_wr_data
);
    localparam int               CNT_W     = (OE_DELAY < 1) ? 1 : $clog2(OE_DELAY + 1);
    localparam logic [CNT_W-1:0] OE_MAX    = CNT_W'(OE_DELAY);
    localparam logic [4:0]       SYNC_IDLE = 5'b01111;

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} exp_state_t;

    exp_state_t       state_q;
    logic [4:0]       sync_q [SYNC_STAGES];
    logic             s_iosel_n, s_iostrobe_n, s_devsel_n, s_rw, s_q3;
    logic             iosel_prev_q, devsel_prev_q, wr_gate_prev_q, armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             data_oe_q, en245_q, strobe_q, strobe_d;
    logic [7:0]       data_out_q, dev_wr_data_q, dev_wr_data_d;
    logic [3:0]       dev_wr_addr_q, dev_wr_addr_d;
    logic [BANK_W-1:0] bank_s;
    logic             iosel_fall_s, devsel_fall_s, wr_gate_s, wr_fire_s, cfff_clr_s;
    logic             rom_sel_s, dev_sel_s, oe_req_s, exp_active_s;

    assign {s_q3, s_rw, s_devsel_n, s_iostrobe_n, s_iosel_n} = sync_q[SYNC_STAGES-1];

    assign iosel_fall_s  = iosel_prev_q & ~s_iosel_n;
    assign devsel_fall_s = devsel_prev_q & ~s_devsel_n;
    assign wr_gate_s     = s_q3 | s_devsel_n;
    assign wr_fire_s     = wr_gate_s & ~wr_gate_prev_q & ~s_rw & armed_q;
    assign cfff_clr_s    = ~s_iostrobe_n & (addr[10:0] == 11'h7FF);
    assign exp_active_s  = (state_q == OWN);
    assign rom_sel_s     = ~s_iosel_n | (~s_iostrobe_n & exp_active_s);
    assign dev_sel_s     = ~s_devsel_n;
    assign oe_req_s      = s_rw & (rom_sel_s | (dev_sel_s & ~addr[0]));

    // Bus strobe synchronisers; flops reset to the idle bus levels.
    always_ff @(posedge fclk) begin
        if (!_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_IDLE;
        end else begin
            sync_q[0] <= {q3, rw, _devsel, _iostrobe, _iosel};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Expansion ROM ownership; a $CFFF access wins over a coincident _iosel fall.
    always_ff @(posedge fclk) begin
        if (!_reset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (iosel_fall_s && !cfff_clr_s) state_q <= OWN;
                OWN:     if (cfff_clr_s) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Next-state for OE counter, write latches and the one-shot strobe arming.
    always_comb begin
        cnt_d         = '0;
        dev_wr_addr_d = dev_wr_addr_q;
        dev_wr_data_d = dev_wr_data_q;
        armed_d       = armed_q;
        if (oe_req_s) begin
            if (cnt_q == OE_MAX) cnt_d = cnt_q;
            else                 cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
        if (devsel_fall_s && !s_rw) dev_wr_addr_d = addr[3:0];
        else                        dev_wr_addr_d = dev_wr_addr_q;
        if (s_q3 && dev_sel_s && !s_rw) dev_wr_data_d = data_in;
        else                            dev_wr_data_d = dev_wr_data_q;
        // Only one strobe per _devsel assertion: re-arm while deasserted.
        if (s_devsel_n)     armed_d = 1'b1;
        else if (wr_fire_s) armed_d = 1'b0;
        else                armed_d = armed_q;
    end

`ifdef ROM_BANK_EN
    logic [BANK_W-1:0] bank_q, bank_d;
    logic              bank_hit_s;

    assign bank_hit_s = (dev_wr_addr_q == BANK_REG_ADDR);
    assign bank_s     = bank_q;

    // Bank register writes are absorbed here instead of reaching the device.
    always_comb begin
        bank_d   = bank_q;
        strobe_d = wr_fire_s & ~bank_hit_s;
        if (wr_fire_s && bank_hit_s) bank_d = dev_wr_data_d[BANK_W-1:0];
        else                         bank_d = bank_q;
    end

    // Bank register storage.
    always_ff @(posedge fclk) begin
        if (!_reset) bank_q <= '0;
        else         bank_q <= bank_d;
    end
`else
    assign bank_s = '0;

    // Without banking every qualified write is forwarded.
    always_comb begin
        strobe_d = wr_fire_s;
    end
`endif

    // Registered outputs and edge-detect history.
    always_ff @(posedge fclk) begin
        if (!_reset) begin
            iosel_prev_q   <= 1'b1;
            devsel_prev_q  <= 1'b1;
            wr_gate_prev_q <= 1'b1;
            armed_q        <= 1'b1;
            cnt_q          <= '0;
            data_oe_q      <= 1'b0;
            en245_q        <= 1'b1;
            data_out_q     <= 8'h00;
            strobe_q       <= 1'b0;
            dev_wr_addr_q  <= 4'h0;
            dev_wr_data_q  <= 8'h00;
        end else begin
            iosel_prev_q   <= s_iosel_n;
            devsel_prev_q  <= s_devsel_n;
            wr_gate_prev_q <= wr_gate_s;
            armed_q        <= armed_d;
            cnt_q          <= cnt_d;
            data_oe_q      <= oe_req_s & (cnt_d == OE_MAX);
            en245_q        <= ~(rom_sel_s | dev_sel_s);
            data_out_q     <= rom_sel_s ? rom_data : dev_data;
            strobe_q       <= strobe_d;
            dev_wr_addr_q  <= dev_wr_addr_d;
            dev_wr_data_q  <= dev_wr_data_d;
        end
    end

    assign data_out      = data_out_q;
    assign data_oe       = data_oe_q;
    assign _en245        = en245_q;
    assign rom_addr      = {bank_s, addr};
    assign exp_active    = exp_active_s;
    assign dev_wr_strobe = strobe_q;
    assign dev_wr_addr   = dev_wr_addr_q;
    assign dev_wr_data   = dev_wr_data_q;
endmodule

// File: doc/apple_bus_frontend.md
Name: apple_bus_frontend

Overview:
- Parametrised Apple II slot bus front-end for the disk controller card; sits between slot pins and internal devices (IWM, code ROM).
- Synchronises bus strobes into the fclk domain and tracks $C800 expansion-ROM ownership.
- Qualifies device register writes, adds a configurable output-enable delay for the 245 buffer, and muxes read data.
- Generalises the previous combinational glue with registered timing, banked ROM and a configurable synchroniser depth.

Parameters:
SYNC_STAGES, 2, flop stages on _iosel, _iostrobe, _devsel, rw, q3 (min 1)
OE_DELAY, 2, fclk cycles a read request must be stable before data_oe asserts (0 = next edge)
BANK_W, 2, ROM bank register width
BANK_REG_ADDR, 4'hE, devsel offset of bank register (used only with ROM_BANK_EN)

Ports:
fclk  in  1  system clock, 7/8 MHz
_reset  in  1  synchronous active-low reset
addr  in  12  bus A11..A0
rw  in  1  1=read, 0=write
q3  in  1  2 MHz timing
_iosel  in  1  slot ROM select, low active
_iostrobe  in  1  $C800-$CFFF strobe, low active
_devsel  in  1  slot I/O select, low active
data_in  in  8  bus data from pad
rom_data  in  8  code ROM output
dev_data  in  8  device read data
data_out  out  8  data to pad
data_oe  out  1  drive pad when 1
_en245  out  1  buffer enable, low active
rom_addr  out  12+BANK_W  {bank, addr}
exp_active  out  1  this card owns $C800 space
dev_wr_strobe  out  1  one-cycle qualified write pulse
dev_wr_addr  out  4  latched A3..A0
dev_wr_data  out  8  latched write data

Behaviour:
- Reset (sampled at fclk edge with _reset=0): data_oe=0, _en245=1, data_out=0, exp_active=0, bank=0, dev_wr_strobe=0, dev_wr_addr=0, dev_wr_data=0; synchroniser flops load inactive levels (strobes 1, rw 1, q3 0). Reset mid-access drops data_oe at that same edge.
- All references below use synchronised signals (s_*); addr and data_in are sampled directly.
- Expansion FSM, states IDLE/OWN:
  - IDLE->OWN on s__iosel falling edge.
  - OWN->IDLE when s__iostrobe=0 and addr[10:0]=11'h7FF ($CFFF, read or write).
  - $CFFF clear wins if both occur in the same cycle.
  - exp_active=1 in OWN.
- rom_sel = ~s__iosel | (~s__iostrobe & exp_active). dev_sel = ~s__devsel.
- oe_req = s_rw & (rom_sel | (dev_sel & addr[0]==0)).
- OE counter:
  - Counts while oe_req=1, saturating at OE_DELAY.
  - data_oe=1 when counter==OE_DELAY and oe_req=1.
  - Clears and data_oe=0 on the first edge with oe_req=0.
  - A glitch resets the count.
- _en245 registered: 0 when rom_sel|dev_sel, else 1.
- data_out registered every cycle: rom_data if rom_sel, else dev_data; rom_sel has priority if both are asserted.
- rom_addr = {bank, addr}, combinational.
- Write path (s_rw=0):
  - dev_wr_addr latched on s__devsel falling edge.
  - dev_wr_data loaded every cycle with s_q3=1 & dev_sel.
  - dev_wr_strobe=1 for exactly one cycle on the rising edge of (s_q3 | s__devsel) when s_rw=0 at that edge.
  - No strobe for reads, and no second strobe until _devsel deasserts and reasserts.

Optional Feature:
ROM_BANK_EN:
- Defined:
  - A qualified write with dev_wr_addr==BANK_REG_ADDR loads bank <= dev_wr_data[BANK_W-1:0] and suppresses dev_wr_strobe for that write.
  - Reads of that offset return dev_data unchanged.
- Undefined:
  - bank is constant 0.
  - All writes, including BANK_REG_ADDR, produce dev_wr_strobe.

Test Plan:
- Reset mid-read: data_oe=1, then _reset=0 for 1 edge -> data_oe=0, _en245=1, exp_active=0 at that edge; all outputs at reset values.
- _iosel low with rw=1, rom_data=8'hA9, OE_DELAY=2 -> data_oe rises SYNC_STAGES+2 edges after _iosel low, data_out=8'hA9, exp_active=1 after _iosel edge.
- With OWN, _iostrobe low at addr 12'h800 -> rom_sel, data driven. Then access addr 12'hFFF -> exp_active=0. A later _iostrobe at 12'h800 -> data_oe stays 0, _en245=1.
- Devsel write, addr 4'h3, data 8'h5C, q3 pulse -> exactly one dev_wr_strobe, dev_wr_addr=4'h3, dev_wr_data=8'h5C. Devsel read at addr 4'h1 (odd) -> data_oe stays 0.
- ROM_BANK_EN, BANK_W=2: write 8'h02 to offset 4'hE -> no strobe; rom_addr[13:12]=2'b10. Without the macro -> strobe pulses, rom_addr[13:12]=0.
- Simultaneous $CFFF clear and rom_sel in OWN with rw=1 -> clear takes effect; next cycle's oe_req=0, counter cleared.
